elevator_ctrl: RTL
==================

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors (2..16).
REQ-002 Parameter TRAVEL_CYCLES, default 4, clock cycles to move one floor (>=1).
REQ-003 Parameter DOOR_CYCLES, default 6, clock cycles door stays open (>=1).
REQ-004 Derived FLOOR_W = $clog2(NUM_FLOORS), floor index width.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 call_valid  input  1  floor call strobe, sampled each cycle.
REQ-008 call_floor  input  FLOOR_W  requested floor index.
REQ-009 emergency_stop  input  1  level; halts car while high.
REQ-010 current_floor  output  FLOOR_W  car position.
REQ-011 floor_led  output  NUM_FLOORS  one-hot of current_floor.
REQ-012 pending  output  NUM_FLOORS  latched outstanding calls.
REQ-013 moving_up / moving_down  output  1 each  car travelling in that direction.
REQ-014 door_open  output  1  door open indication.

Function
REQ-015 Accepted call sets pending[call_floor] on the next edge; call_floor >= NUM_FLOORS ignored.
REQ-016 States IDLE, MOVE, DOOR, HALT; direction register dir (UP/DOWN) retained across states.
REQ-017 IDLE: pending[current_floor] -> DOOR; else pending ahead of dir -> MOVE same dir; else pending behind -> flip dir, MOVE; else stay IDLE.
REQ-018 MOVE: travel counter counts TRAVEL_CYCLES; on terminal cycle current_floor +/-1 per dir, counter reloads.
REQ-019 Arrival: pending[new floor] -> DOOR; else pending still ahead -> continue MOVE; else IDLE.
REQ-020 Entering DOOR clears pending[current_floor] same edge; door_open high exactly DOOR_CYCLES cycles, then IDLE.
REQ-021 Call for current_floor during DOOR not latched; restarts door count to DOOR_CYCLES.
REQ-022 Call for current_floor in IDLE latched; DOOR entered following cycle.
REQ-023 Set and clear of same pending bit on same edge outside DOOR: set wins.
REQ-024 current_floor never below 0 or above NUM_FLOORS-1; no wrap-around.
REQ-025 emergency_stop high in any state -> HALT next edge; partial travel discarded, floor held, door_open=0, moving_*=0.
REQ-026 HALT: calls still latched; on emergency_stop low -> IDLE next edge, counters reloaded.
REQ-027 moving_up = (state==MOVE && dir==UP); moving_down analogous; never both high.
REQ-028 floor_led combinational from current_floor, always exactly one bit set.

Reset
REQ-029 Reset forces state=IDLE, dir=UP, current_floor=0, floor_led=1, pending=0, door_open=0, moving_*=0, counters reloaded.
REQ-030 Reset asserted mid-MOVE or mid-DOOR takes effect immediately; no call survives reset.

Structure
REQ-031 Package elevator_pkg holds state enum, dir enum, parameter defaults.
REQ-032 One sub-module elev_timer: loadable down-counter, shared for travel and door timing, terminal-count output.

Verification
REQ-033 Reset, defaults -> current_floor=0, floor_led=8'b00000001, pending=0, door_open=0.
REQ-034 At floor 0 IDLE, call 3 -> pending=8'b00001000 next cycle; floor 3 after 12 MOVE cycles; door_open 6 cycles; pending=0.
REQ-035 Moving up at floor 2 with pending 5, call 1 -> stops 5 (door), then reverses, stops 1.
REQ-036 In DOOR at floor 4, call 4 on door cycle 5 -> door_open lasts 6 further cycles; pending unchanged.
REQ-037 emergency_stop 3 cycles mid-travel floor 1->2 -> HALT, floor 1 held, outputs low; then resumes, reaches 2 after full 4 cycles.
REQ-038 NUM_FLOORS=6, call 7 -> ignored, pending=0; reset during MOVE -> floor 0, pending=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and parameter defaults for the elevator controller.
package elevator_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StMove,
        StDoor,
        StHalt
    } state_e;

    typedef enum logic {
        DirUp,
        DirDown
    } dir_e;

    localparam int unsigned DefNumFloors    = 8;
    localparam int unsigned DefTravelCycles = 4;
    localparam int unsigned DefDoorCycles   = 6;

endpackage

// File: rtl/elevator_ctrl_timer.sv
// Loadable down-counter shared by travel and door timing; saturates at zero.
module elev_timer #(
    parameter int unsigned      CNT_W     = 3,
    parameter logic [CNT_W-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= RESET_VAL;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/elevator_ctrl.sv
// Single-car elevator controller: latches floor calls, serves them in the current
// direction first, then reverses; emergency stop parks the car until released.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned  NUM_FLOORS    = DefNumFloors,
    parameter int unsigned  TRAVEL_CYCLES = DefTravelCycles,
    parameter int unsigned  DOOR_CYCLES   = DefDoorCycles,
    localparam int unsigned FLOOR_W       = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  call_valid,
    input  logic [FLOOR_W-1:0]    call_floor,
    input  logic                  emergency_stop,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] floor_led,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  moving_up,
    output logic                  moving_down,
    output logic                  door_open
);

    localparam int unsigned MaxCycles =
        (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned CntW = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES - 1);
    localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TopFloor = FLOOR_W'(NUM_FLOORS - 1);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d, dir_flip;
    logic [FLOOR_W-1:0]    floor_q, floor_d, floor_next;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, clr_mask;
    logic                  tmr_load, tmr_tc;
    logic [CntW-1:0]       tmr_val;
    logic                  call_ok, door_hit;

    // True when any latched call lies strictly beyond floor f in direction d.
    function automatic logic any_ahead(input logic [NUM_FLOORS-1:0] p,
                                       input logic [FLOOR_W-1:0] f, input dir_e d);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (p[i] && ((d == DirUp) ? (i > int'(f)) : (i < int'(f)))) hit = 1'b1;
        end
        return hit;
    endfunction

    elev_timer #(
        .CNT_W    (CntW),
        .RESET_VAL(TravelLoad)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tc      (tmr_tc)
    );

    assign call_ok  = call_valid && (int'(call_floor) < int'(NUM_FLOORS));
    assign door_hit = call_ok && (state_q == StDoor) && (call_floor == floor_q);
    assign dir_flip = (dir_q == DirUp) ? DirDown : DirUp;

    always_comb begin
        floor_next = floor_q;
        if (dir_q == DirUp) begin
            if (floor_q != TopFloor) floor_next = floor_q + FLOOR_W'(1);
        end else if (floor_q != '0) begin
            floor_next = floor_q - FLOOR_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        floor_d  = floor_q;
        tmr_load = 1'b0;
        tmr_val  = TravelLoad;
        set_mask = '0;
        clr_mask = '0;
        // A call for the floor whose door is already open only extends the door time.
        if (call_ok && !door_hit) set_mask[call_floor] = 1'b1;

        if (emergency_stop) begin
            state_d  = StHalt;
            tmr_load = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tmr_load = 1'b1;
                    if (pending_q[floor_q]) begin
                        state_d            = StDoor;
                        clr_mask[floor_q]  = 1'b1;
                        tmr_val            = DoorLoad;
                    end else if (any_ahead(pending_q, floor_q, dir_q)) begin
                        state_d = StMove;
                    end else if (any_ahead(pending_q, floor_q, dir_flip)) begin
                        state_d = StMove;
                        dir_d   = dir_flip;
                    end
                end
                StMove: begin
                    if (tmr_tc) begin
                        floor_d  = floor_next;
                        tmr_load = 1'b1;
                        if (pending_q[floor_next]) begin
                            state_d              = StDoor;
                            clr_mask[floor_next] = 1'b1;
                            tmr_val              = DoorLoad;
                        end else if (!any_ahead(pending_q, floor_next, dir_q)) begin
                            state_d = StIdle;
                        end
                    end
                end
                StDoor: begin
                    if (door_hit) begin
                        tmr_load = 1'b1;
                        tmr_val  = DoorLoad;
                    end else if (tmr_tc) begin
                        state_d  = StIdle;
                        tmr_load = 1'b1;
                    end
                end
                StHalt: begin
                    state_d  = StIdle;
                    tmr_load = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end

        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            dir_q       <= DirUp;
            floor_q     <= '0;
            pending_q   <= '0;
            door_open   <= 1'b0;
            moving_up   <= 1'b0;
            moving_down <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            floor_q     <= floor_d;
            pending_q   <= pending_d;
            door_open   <= (state_d == StDoor);
            moving_up   <= (state_d == StMove) && (dir_d == DirUp);
            moving_down <= (state_d == StMove) && (dir_d == DirDown);
        end
    end

    assign current_floor = floor_q;
    assign pending       = pending_q;
    assign floor_led     = {{(NUM_FLOORS - 1){1'b0}}, 1'b1} << floor_q;

endmodule
